// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and
// the width helper for the multiply iteration counter.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_MUL   = 3'b101,
    OP_PASSA = 3'b110,
    OP_RSV   = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  // Counter must hold the value W itself, hence W+1 states.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/add_rca_n.sv
// W-bit ripple-carry adder built as a chain of full-adder cells.
module add_rca_n
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         c_out,
  output logic [W-1:0] sum
);

  // Ripple the carry through one full-adder cell per bit.
  always_comb begin
    logic cy;
    cy  = c_in;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle add/sub/logic/pass ops and an
// unsigned W x W shift-and-add multiply taking W cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         overflow
);

  localparam int               CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic [W-1:0]     result_hi_q, result_hi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  op_e          op_w;
  logic         is_sub;
  logic [W-1:0] as_b;
  logic [W-1:0] as_sum;
  logic         as_cout;
  logic [W-1:0] mac_b;
  logic [W-1:0] mac_sum;
  logic         mac_cout;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic ovf_add(input logic signed [W-1:0] x,
                                   input logic signed [W-1:0] y,
                                   input logic signed [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Subtraction overflows when signs differ and the result leaves a's sign.
  function automatic logic ovf_sub(input logic signed [W-1:0] x,
                                   input logic signed [W-1:0] y,
                                   input logic signed [W-1:0] s);
    return (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  assign op_w   = op_e'(op);
  assign is_sub = (op_w == OP_SUB);
  assign as_b   = is_sub ? ~b : b;

  add_rca_n #(.W(W)) u_addsub (
    .a     (a),
    .b     (as_b),
    .c_in  (is_sub),
    .c_out (as_cout),
    .sum   (as_sum)
  );

  // Accumulate step adds the multiplicand only when the multiplier LSB is set.
  assign mac_b = mcand_q & {W{mplier_q[0]}};

  add_rca_n #(.W(W)) u_mulacc (
    .a     (acc_q),
    .b     (mac_b),
    .c_in  (1'b0),
    .c_out (mac_cout),
    .sum   (mac_sum)
  );

  // Next-state, multiply datapath and output update; outputs hold unless an op completes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_w == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_LOAD;
            state_d  = ST_MUL_RUN;
          end else begin
            done_d      = 1'b1;
            result_hi_d = '0;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            case (op_w)
              OP_ADD: begin
                result_d = as_sum;
                carry_d  = as_cout;
                ovf_d    = ovf_add(a, b, as_sum);
              end
              OP_SUB: begin
                result_d = as_sum;
                carry_d  = as_cout;
                ovf_d    = ovf_sub(a, b, as_sum);
              end
              OP_AND:  result_d = a & b;
              OP_OR:   result_d = a | b;
              OP_XOR:  result_d = a ^ b;
              default: result_d = a;
            endcase
            zero_d = (result_d == '0);
          end
        end
      end
      ST_MUL_RUN: begin
        // {carry, acc, multiplier} shifted right by one after the add.
        acc_d    = {mac_cout, mac_sum[W-1:1]};
        mplier_d = {mac_sum[0], mplier_q[W-1:1]};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          result_hi_d = acc_d;
          result_d    = mplier_d;
          carry_d     = |acc_d;
          zero_d      = ~|{acc_d, mplier_d};
          ovf_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and visible outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  // Multiply working registers; always loaded on start so no reset needed.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  assign busy      = (state_q == ST_MUL_RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with an arithmetic reference model.
module tb_alu_seq;

  localparam int     W    = 8;
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_hi  = '0;
  logic         m_c   = 1'b0;
  logic         m_z   = 1'b0;
  logic         m_v   = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] p_lo = '0;
  logic [W-1:0] p_hi = '0;
  int           pend = 0;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluates each accepted request with plain arithmetic.
  initial begin : model_proc
    longint ua, ub, sa, sb, r;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_res = '0; m_hi = '0; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0;
        m_done = 1'b0; pend = 0;
      end else if (pend != 0) begin
        m_done = 1'b0;
        pend   = pend - 1;
        if (pend == 0) begin
          m_hi = p_hi; m_res = p_lo; m_c = (p_hi != '0);
          m_z = (p_hi == '0) && (p_lo == '0); m_v = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= HALF) ? ua - FULL : ua;
        sb = (ub >= HALF) ? ub - FULL : ub;
        if (op == 3'd5) begin
          r    = ua * ub;
          p_lo = r[W-1:0];
          p_hi = r[2*W-1:W];
          pend = W;
          m_done = 1'b0;
        end else begin
          m_hi = '0; m_c = 1'b0; m_v = 1'b0;
          case (op)
            3'd0: begin
              r = ua + ub; m_res = r[W-1:0]; m_c = (r >= FULL);
              m_v = (sa + sb >= HALF) || (sa + sb < -HALF);
            end
            3'd1: begin
              r = ua - ub + FULL; m_res = r[W-1:0]; m_c = (ua >= ub);
              m_v = (sa - sb >= HALF) || (sa - sb < -HALF);
            end
            3'd2:    m_res = a & b;
            3'd3:    m_res = a | b;
            3'd4:    m_res = a ^ b;
            default: m_res = a;
          endcase
          m_z = (m_res == '0);
          m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin : compare_proc
    forever begin
      @(negedge clk);
      chk1("cmp_done", done, m_done);
      chk1("cmp_busy", busy, pend != 0);
      chkw("cmp_result", result, m_res);
      chkw("cmp_result_hi", result_hi, m_hi);
      chk1("cmp_carry", carry, m_c);
      chk1("cmp_zero", zero, m_z);
      chk1("cmp_overflow", overflow, m_v);
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chkw("rst_result", result, 8'h00);
    chkw("rst_result_hi", result_hi, 8'h00);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    drive(3'd0, 8'hF0, 8'h20);
    chkw("add_res", result, 8'h10);
    chk1("add_c", carry, 1'b1);
    chk1("add_v", overflow, 1'b0);
    chk1("add_z", zero, 1'b0);
    chk1("add_done", done, 1'b1);
    chk1("add_busy", busy, 1'b0);
    @(negedge clk);
    chk1("add_done_pulse", done, 1'b0);

    // Back-to-back single-cycle ops
    drive(3'd1, 8'h80, 8'h01);
    chkw("sub1_res", result, 8'h7F);
    chk1("sub1_c", carry, 1'b1);
    chk1("sub1_v", overflow, 1'b1);
    drive(3'd1, 8'h01, 8'h02);
    chkw("sub2_res", result, 8'hFF);
    chk1("sub2_c", carry, 1'b0);
    chk1("sub2_v", overflow, 1'b0);
    chk1("b2b_done", done, 1'b1);
    drive(3'd0, 8'h7F, 8'h01);
    chkw("addv_res", result, 8'h80);
    chk1("addv_v", overflow, 1'b1);
    chk1("addv_c", carry, 1'b0);
    drive(3'd2, 8'hF0, 8'h3C);
    chkw("and_res", result, 8'h30);
    drive(3'd3, 8'hF0, 8'h0F);
    chkw("or_res", result, 8'hFF);
    drive(3'd4, 8'h5A, 8'h5A);
    chkw("xor_res", result, 8'h00);
    chk1("xor_z", zero, 1'b1);
    chk1("xor_c", carry, 1'b0);
    chk1("xor_v", overflow, 1'b0);
    chkw("xor_hi", result_hi, 8'h00);
    drive(3'd7, 8'h3C, 8'hC3);
    chkw("rsv_res", result, 8'h3C);
    drive(3'd6, 8'hA5, 8'h11);
    chkw("passa_res", result, 8'hA5);
    chk1("passa_done", done, 1'b1);
    @(negedge clk);

    // Multiply FF x FF
    drive(3'd5, 8'hFF, 8'hFF);
    chk1("mul_busy0", busy, 1'b1);
    chk1("mul_nodone0", done, 1'b0);
    chkw("mul_hold_res", result, 8'hA5);
    wait_done(20, lat);
    chki("mul_latency", lat, W);
    chkw("mul_hi", result_hi, 8'hFE);
    chkw("mul_lo", result, 8'h01);
    chk1("mul_c", carry, 1'b1);
    chk1("mul_z", zero, 1'b0);
    chk1("mul_busy_end", busy, 1'b0);
    @(negedge clk);

    drive(3'd5, 8'h00, 8'h37);
    wait_done(20, lat);
    chki("mul0_latency", lat, W);
    chkw("mul0_lo", result, 8'h00);
    chk1("mul0_z", zero, 1'b1);
    chk1("mul0_c", carry, 1'b0);

    drive(3'd5, 8'h80, 8'h02);
    wait_done(20, lat);
    chkw("mul2_hi", result_hi, 8'h01);
    chkw("mul2_lo", result, 8'h00);
    chk1("mul2_z", zero, 1'b0);
    chk1("mul2_c", carry, 1'b1);

    // Requests while busy are dropped; first request after done is taken
    drive(3'd5, 8'h12, 8'h34);
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      start = 1'b1; op = 3'd0; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    chk1("ign_done", done, 1'b1);
    chkw("ign_hi", result_hi, 8'h03);
    chkw("ign_lo", result, 8'hA8);
    start = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    chk1("after_done", done, 1'b1);
    chkw("after_res", result, 8'h33);
    chkw("after_hi", result_hi, 8'h00);

    // Reset in the middle of a multiply
    drive(3'd5, 8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chkw("abort_res", result, 8'h00);
    chkw("abort_hi", result_hi, 8'h00);
    chk1("abort_c", carry, 1'b0);
    chk1("abort_z", zero, 1'b0);
    chk1("abort_v", overflow, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
